input_repeat_ctrl: RTL and testbench
====================================

# input_repeat_ctrl

Schedules player move commands from held-key levels produced by the PS/2 keyboard decoder. It converts the key levels into single-cycle command pulses for the Tetris game logic. It applies delayed auto-shift (DAS) and auto-repeat (ARR) to horizontal moves, fixed-rate repeat to soft drop, and edge-only triggering to rotate and hard drop. It sits between the keyboard decoder and the game FSM, and arbitrates conflicting left/right requests.

## Interface
- DAS_CYCLES, default 16_000_000: clock cycles from the initial horizontal pulse to the first repeat. Must be ≥1.
- ARR_CYCLES, default 4_000_000: clock cycles between horizontal repeats. Must be ≥1.
- SOFT_CYCLES, default 5_000_000: clock cycles between soft-drop repeats. Must be ≥1.
- clk  in  1  system clock; all inputs are synchronous to it.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  game active. When low, all state is cleared and all pulses are suppressed.
- key_left, key_right, key_down, key_rotate, key_drop  in  1 each  held-key levels from the decoder.
- move_left, move_right, move_down, rotate, hard_drop  out  1 each  registered single-cycle command pulses.

## Operation
- Reset: all outputs are 0, both FSMs are in IDLE, counters are 0, and the previous-level registers are 0.
- Edge detection: a rising edge is the key sampled at 1 while its previous-level register holds 0. Previous-level registers update every edge.
- rotate and hard_drop pulse once per rising edge of their key. They never repeat.
- Horizontal FSM uses states H_IDLE, H_DAS and H_ARR, plus a direction register `dir`.
  - H_IDLE, left or right rises: set `dir` to that key, pulse it, load the counter with DAS_CYCLES-1, go to H_DAS. If both rise on the same edge, left wins.
  - H_DAS / H_ARR with the `dir` key held: if the counter is 0, pulse `dir`, load ARR_CYCLES-1 and go to (or stay in) H_ARR. Otherwise decrement the counter.
  - Opposite key rises while in H_DAS or H_ARR (last pressed wins): switch `dir`, pulse the new direction, load DAS_CYCLES-1, go to H_DAS.
  - `dir` key released while the opposite key is held: switch `dir`, load DAS_CYCLES-1, go to H_DAS. No pulse is issued on that edge.
  - `dir` key released with the opposite key not held: go to H_IDLE and clear the counter. No pulse is issued.
- Vertical FSM uses states V_IDLE and V_REP.
  - key_down rises: pulse move_down, load SOFT_CYCLES-1, go to V_REP.
  - V_REP with key_down held: if the counter is 0, pulse and reload. Otherwise decrement.
  - key_down released: go to V_IDLE.
- Hard-drop priority: on any edge that asserts hard_drop, move_left, move_right, move_down and rotate are forced to 0. FSMs and counters still advance normally, so any suppressed pulse is lost and is not deferred.
- enable low, on every edge:
  - all outputs are 0;
  - FSMs are forced to IDLE and counters to 0;
  - previous-level registers still load the current key levels.
  - A key held while enable rises therefore produces no pulse until it is released and re-pressed.
- Counter width: $clog2(max(DAS_CYCLES, ARR_CYCLES, SOFT_CYCLES)) bits, minimum 1. Counters never wrap below 0.
- At most one of move_left and move_right is high on any cycle.

## Timing
- Latency is one clock: a pulse is visible for exactly the one cycle after the edge that detects its condition.
- A horizontal key held from edge 0 pulses on edges 0, DAS, DAS+ARR, DAS+2·ARR, and so on.
- Soft drop held from edge 0 pulses on edges 0, SOFT, 2·SOFT, and so on.
- ARR_CYCLES=1 or SOFT_CYCLES=1 produces a pulse on every edge in the repeat state.
- Asynchronous reset mid-operation: outputs drop to 0 immediately and no pulse follows deassertion. Keys held through reset pulse on the first post-reset edge, because the previous-level registers reset to 0.
- No handshake: the consumer must sample the pulses every cycle.

## Test plan
All scenarios use DAS_CYCLES=4, ARR_CYCLES=2, SOFT_CYCLES=3 and enable=1 unless stated otherwise.
- Hold key_left from edge 0 through edge 11, then release → move_left pulses on edges 0, 4, 6, 8, 10 and nothing after.
- Hold left from edge 0, press right at edge 5 and hold it → left pulses on edges 0 and 4; right pulses on edges 5, 9, 11. move_left is never high together with move_right.
- Left and right rise on the same edge 0 → move_left on edge 0 only and no right pulse. Release left at edge 2 → move_right pulses on edges 6, 8.
- Hold key_down from edge 0, press key_drop at edge 3 → hard_drop on edge 3 with move_down suppressed on that edge. move_down pulses on edges 0 and 6.
- Hold rotate for 10 edges → exactly one rotate pulse. Hold left while enable=0, raise enable → no pulse until left is released and re-pressed.
- Assert rst_n low mid-H_ARR → all outputs 0 asynchronously. Release reset with left held → move_left on the first edge, then on edge 4 after it.

Source files
------------

// File: rtl/input_repeat_ctrl.sv
// -----------------------------------------------------------------------------
// input_repeat_ctrl
//
// Purpose:
//    Turns held-key levels from the keyboard decoder into single-cycle move
//    command pulses for the game logic. Horizontal moves use delayed
//    auto-shift followed by auto-repeat, with last-pressed-wins arbitration
//    between left and right. Soft drop repeats at a fixed rate. Rotate and
//    hard drop fire once per press. A hard-drop pulse masks every other
//    pulse on the same cycle.
//
// Parameters:
//    DAS_CYCLES   cycles from the initial horizontal pulse to the first repeat (>=1)
//    ARR_CYCLES   cycles between horizontal repeats (>=1)
//    SOFT_CYCLES  cycles between soft-drop repeats (>=1)
//
// Ports:
//    clk            system clock
//    rst_n          asynchronous active-low reset
//    enable_i       game active; low clears all state and suppresses pulses
//    key_left_i     held level, move left
//    key_right_i    held level, move right
//    key_down_i     held level, soft drop
//    key_rotate_i   held level, rotate
//    key_drop_i     held level, hard drop
//    move_left_o    registered one-cycle pulse
//    move_right_o   registered one-cycle pulse
//    move_down_o    registered one-cycle pulse
//    rotate_o       registered one-cycle pulse
//    hard_drop_o    registered one-cycle pulse
// -----------------------------------------------------------------------------
module input_repeat_ctrl #(
   parameter int unsigned DAS_CYCLES  = 16_000_000,
   parameter int unsigned ARR_CYCLES  = 4_000_000,
   parameter int unsigned SOFT_CYCLES = 5_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable_i,
   input  logic key_left_i,
   input  logic key_right_i,
   input  logic key_down_i,
   input  logic key_rotate_i,
   input  logic key_drop_i,
   output logic move_left_o,
   output logic move_right_o,
   output logic move_down_o,
   output logic rotate_o,
   output logic hard_drop_o
);

   // Counters only ever hold (cycles - 1), so $clog2 of the largest period suffices.
   localparam int unsigned MAX_DA  = (DAS_CYCLES > ARR_CYCLES) ? DAS_CYCLES : ARR_CYCLES;
   localparam int unsigned MAX_CYC = (MAX_DA > SOFT_CYCLES) ? MAX_DA : SOFT_CYCLES;
   localparam int          CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [CNT_W-1:0] DAS_LOAD  = CNT_W'(DAS_CYCLES - 1);
   localparam logic [CNT_W-1:0] ARR_LOAD  = CNT_W'(ARR_CYCLES - 1);
   localparam logic [CNT_W-1:0] SOFT_LOAD = CNT_W'(SOFT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   // Bit positions inside the packed key / pulse vectors
   localparam int K_LEFT  = 0;
   localparam int K_RIGHT = 1;
   localparam int K_DOWN  = 2;
   localparam int K_ROT   = 3;
   localparam int K_DROP  = 4;

   typedef enum logic [1:0] {H_IDLE, H_DAS, H_ARR} h_state_e;
   typedef enum logic       {V_IDLE, V_REP}        v_state_e;

   logic [4:0]       keys;
   logic [4:0]       prev_q;
   logic [4:0]       rise;

   h_state_e         h_state_q, h_state_d;
   logic             dir_q, dir_d;          // 0 = left, 1 = right
   logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
   logic             h_pulse_l, h_pulse_r;

   v_state_e         v_state_q, v_state_d;
   logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
   logic             v_pulse;

   logic [4:0]       out_q, out_d;

   logic             cur_held, opp_held, opp_rise;

   assign keys = {key_drop_i, key_rotate_i, key_down_i, key_right_i, key_left_i};

   // Rising edge: key high now, low on the previous edge
   generate
      for (genvar gi = 0; gi < 5; gi++) begin : g_edge
         assign rise[gi] = keys[gi] & ~prev_q[gi];
      end
   endgenerate

   // Keys seen relative to the currently active direction
   assign cur_held = dir_q ? keys[K_RIGHT] : keys[K_LEFT];
   assign opp_held = dir_q ? keys[K_LEFT]  : keys[K_RIGHT];
   assign opp_rise = dir_q ? rise[K_LEFT]  : rise[K_RIGHT];

   // ---------------------------------------------------------------- horizontal
   always_comb begin
      h_state_d = h_state_q;
      dir_d     = dir_q;
      h_cnt_d   = h_cnt_q;
      h_pulse_l = 1'b0;
      h_pulse_r = 1'b0;

      case (h_state_q)
         H_IDLE: begin
            // Left takes precedence when both arrive together
            if (rise[K_LEFT]) begin
               dir_d     = 1'b0;
               h_pulse_l = 1'b1;
               h_cnt_d   = DAS_LOAD;
               h_state_d = H_DAS;
            end else if (rise[K_RIGHT]) begin
               dir_d     = 1'b1;
               h_pulse_r = 1'b1;
               h_cnt_d   = DAS_LOAD;
               h_state_d = H_DAS;
            end
         end

         H_DAS, H_ARR: begin
            if (opp_rise) begin
               // Freshly pressed opposite key takes over immediately
               dir_d     = ~dir_q;
               h_pulse_l = dir_q;
               h_pulse_r = ~dir_q;
               h_cnt_d   = DAS_LOAD;
               h_state_d = H_DAS;
            end else if (!cur_held) begin
               if (opp_held) begin
                  // Fall back to the still-held key, silently restarting DAS
                  dir_d     = ~dir_q;
                  h_cnt_d   = DAS_LOAD;
                  h_state_d = H_DAS;
               end else begin
                  h_cnt_d   = '0;
                  h_state_d = H_IDLE;
               end
            end else if (h_cnt_q == '0) begin
               h_pulse_l = ~dir_q;
               h_pulse_r = dir_q;
               h_cnt_d   = ARR_LOAD;
               h_state_d = H_ARR;
            end else begin
               h_cnt_d = h_cnt_q - CNT_ONE;
            end
         end

         default: begin
            h_cnt_d   = '0;
            h_state_d = H_IDLE;
         end
      endcase

      if (!enable_i) begin
         h_state_d = H_IDLE;
         h_cnt_d   = '0;
         h_pulse_l = 1'b0;
         h_pulse_r = 1'b0;
      end
   end

   // ------------------------------------------------------------------ vertical
   always_comb begin
      v_state_d = v_state_q;
      v_cnt_d   = v_cnt_q;
      v_pulse   = 1'b0;

      case (v_state_q)
         V_IDLE: begin
            if (rise[K_DOWN]) begin
               v_pulse   = 1'b1;
               v_cnt_d   = SOFT_LOAD;
               v_state_d = V_REP;
            end
         end

         V_REP: begin
            if (!keys[K_DOWN]) begin
               v_state_d = V_IDLE;
            end else if (v_cnt_q == '0) begin
               v_pulse = 1'b1;
               v_cnt_d = SOFT_LOAD;
            end else begin
               v_cnt_d = v_cnt_q - CNT_ONE;
            end
         end

         default: begin
            v_cnt_d   = '0;
            v_state_d = V_IDLE;
         end
      endcase

      if (!enable_i) begin
         v_state_d = V_IDLE;
         v_cnt_d   = '0;
         v_pulse   = 1'b0;
      end
   end

   // ------------------------------------------------------------------- outputs
   always_comb begin
      out_d          = '0;
      out_d[K_LEFT]  = h_pulse_l;
      out_d[K_RIGHT] = h_pulse_r;
      out_d[K_DOWN]  = v_pulse;
      out_d[K_ROT]   = rise[K_ROT];
      out_d[K_DROP]  = rise[K_DROP];
      // Hard drop masks everything else; masked pulses are simply lost
      if (out_d[K_DROP]) begin
         out_d[K_ROT:K_LEFT] = '0;
      end
      if (!enable_i) begin
         out_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q    <= '0;
         h_state_q <= H_IDLE;
         dir_q     <= 1'b0;
         h_cnt_q   <= '0;
         v_state_q <= V_IDLE;
         v_cnt_q   <= '0;
         out_q     <= '0;
      end else begin
         // Tracks keys even while disabled so held keys need a re-press
         prev_q    <= keys;
         h_state_q <= h_state_d;
         dir_q     <= dir_d;
         h_cnt_q   <= h_cnt_d;
         v_state_q <= v_state_d;
         v_cnt_q   <= v_cnt_d;
         out_q     <= out_d;
      end
   end

   assign move_left_o  = out_q[K_LEFT];
   assign move_right_o = out_q[K_RIGHT];
   assign move_down_o  = out_q[K_DOWN];
   assign rotate_o     = out_q[K_ROT];
   assign hard_drop_o  = out_q[K_DROP];

endmodule

// File: tb/tb_input_repeat_ctrl.sv
// -----------------------------------------------------------------------------
// tb_input_repeat_ctrl
//
// Purpose:
//    Drives input_repeat_ctrl (DAS=4, ARR=2, SOFT=3) with directed scenarios
//    followed by random key activity. A timing-based model predicts each
//    cycle's pulses from press times and elapsed edges. Directed scenarios
//    additionally pin both model and design to hand-derived pulse masks.
// -----------------------------------------------------------------------------
module tb_input_repeat_ctrl;

   localparam int DAS  = 4;
   localparam int ARR  = 2;
   localparam int SOFT = 3;

   localparam bit [4:0] KL = 5'b00001;
   localparam bit [4:0] KR = 5'b00010;
   localparam bit [4:0] KD = 5'b00100;
   localparam bit [4:0] KT = 5'b01000;
   localparam bit [4:0] KX = 5'b10000;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       en    = 1'b1;
   logic [4:0] keys  = '0;
   logic       ml, mr, md, mrot, mdrop;

   always #5 clk = ~clk;

   input_repeat_ctrl #(
      .DAS_CYCLES (DAS),
      .ARR_CYCLES (ARR),
      .SOFT_CYCLES(SOFT)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable_i    (en),
      .key_left_i  (keys[0]),
      .key_right_i (keys[1]),
      .key_down_i  (keys[2]),
      .key_rotate_i(keys[3]),
      .key_drop_i  (keys[4]),
      .move_left_o (ml),
      .move_right_o(mr),
      .move_down_o (md),
      .rotate_o    (mrot),
      .hard_drop_o (mdrop)
   );

   int vectors    = 0;
   int miscompares = 0;

   // ------------------------------------------------------------ reference model
   // Horizontal repeats are derived from the edge at which the current
   // direction started: offset 0 pulses only for a fresh press, then offsets
   // DAS, DAS+ARR, ... Soft drop pulses at offsets 0, SOFT, 2*SOFT, ...
   int       n_m    = 0;
   bit [4:0] prev_m = '0;
   bit       h_act  = 1'b0;
   bit       h_dir  = 1'b0;
   int       h_t0   = 0;
   bit       v_act  = 1'b0;
   int       v_t0   = 0;
   bit [4:0] exp_m  = '0;

   function automatic void model_reset();
      prev_m = '0;
      h_act  = 1'b0;
      v_act  = 1'b0;
      exp_m  = '0;
   endfunction

   function automatic void model_step(input bit [4:0] k, input bit e);
      bit [4:0] rs;
      bit [4:0] p;
      int       cur;
      int       opp;
      int       d;
      p = '0;
      if (!e) begin
         prev_m = k;
         h_act  = 1'b0;
         v_act  = 1'b0;
         exp_m  = '0;
         n_m++;
         return;
      end
      rs = k & ~prev_m;
      if (!h_act) begin
         if (rs[0]) begin
            h_act = 1'b1; h_dir = 1'b0; h_t0 = n_m; p[0] = 1'b1;
         end else if (rs[1]) begin
            h_act = 1'b1; h_dir = 1'b1; h_t0 = n_m; p[1] = 1'b1;
         end
      end else begin
         cur = h_dir ? 1 : 0;
         opp = 1 - cur;
         if (rs[opp]) begin
            h_dir = ~h_dir; h_t0 = n_m; p[opp] = 1'b1;
         end else if (!k[cur]) begin
            if (k[opp]) begin
               h_dir = ~h_dir; h_t0 = n_m;
            end else begin
               h_act = 1'b0;
            end
         end else begin
            d = n_m - h_t0;
            if (d >= DAS && ((d - DAS) % ARR) == 0) p[cur] = 1'b1;
         end
      end
      if (!v_act) begin
         if (rs[2]) begin
            v_act = 1'b1; v_t0 = n_m; p[2] = 1'b1;
         end
      end else if (!k[2]) begin
         v_act = 1'b0;
      end else if (((n_m - v_t0) % SOFT) == 0) begin
         p[2] = 1'b1;
      end
      p[3] = rs[3];
      p[4] = rs[4];
      if (p[4]) p[3:0] = '0;
      exp_m  = p;
      prev_m = k;
      n_m++;
   endfunction

   task automatic check_out(input bit [4:0] expv, input string what);
      logic [4:0] got;
      got = {mdrop, mrot, md, mr, ml};
      vectors++;
      if (got !== expv) begin
         miscompares++;
         $display("FAIL %s edge %0d: dut=%b required=%b", what, n_m - 1, got, expv);
      end
      vectors++;
      if (ml === 1'b1 && mr === 1'b1) begin
         miscompares++;
         $display("FAIL %s edge %0d: left and right both high", what, n_m - 1);
      end
   endtask

   // Single compare process: advance the model on each edge, check 1 time unit later
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         model_reset();
         #1;
         check_out(5'b00000, "reset");
      end else begin
         model_step(keys, en);
         #1;
         check_out(exp_m, "cycle");
      end
   end

   // ----------------------------------------------------- directed pulse masks
   int          rel = 0;
   logic [31:0] m_mask [5];
   logic [31:0] d_mask [5];

   task automatic start_scen();
      rel = 0;
      for (int i = 0; i < 5; i++) begin
         m_mask[i] = '0;
         d_mask[i] = '0;
      end
   endtask

   task automatic cyc(input bit [4:0] k);
      logic [4:0] got;
      @(negedge clk);
      keys = k;
      @(posedge clk);
      #2;
      got = {mdrop, mrot, md, mr, ml};
      if (rel < 32) begin
         for (int i = 0; i < 5; i++) begin
            m_mask[i][rel] = exp_m[i];
            d_mask[i][rel] = got[i];
         end
      end
      rel++;
   endtask

   task automatic pin(input string nm, input int idx, input logic [31:0] want);
      vectors++;
      if (m_mask[idx] !== want) begin
         miscompares++;
         $display("FAIL %s model: got %h required %h", nm, m_mask[idx], want);
      end
      vectors++;
      if (d_mask[idx] !== want) begin
         miscompares++;
         $display("FAIL %s dut: got %h required %h", nm, d_mask[idx], want);
      end
   endtask

   initial begin
      bit [4:0] rk;
      rst_n = 1'b0;
      keys  = '0;
      en    = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) cyc('0);

      // Left held edges 0..11
      start_scen();
      repeat (12) cyc(KL);
      repeat (4) cyc('0);
      pin("s1_left", 0, 32'h0000_0551);
      pin("s1_right", 1, 32'h0000_0000);
      $display("scenario hold-left done");

      // Left held, right pressed at edge 5
      start_scen();
      repeat (5) cyc(KL);
      repeat (7) cyc(KL | KR);
      repeat (4) cyc('0);
      pin("s2_left", 0, 32'h0000_0011);
      pin("s2_right", 1, 32'h0000_0A20);
      $display("scenario left-then-right done");

      // Both pressed together, left released at edge 2
      start_scen();
      repeat (2) cyc(KL | KR);
      repeat (8) cyc(KR);
      repeat (3) cyc('0);
      pin("s3_left", 0, 32'h0000_0001);
      pin("s3_right", 1, 32'h0000_0140);
      $display("scenario simultaneous done");

      // Soft drop with hard drop at edge 3
      start_scen();
      repeat (3) cyc(KD);
      repeat (5) cyc(KD | KX);
      repeat (3) cyc('0);
      pin("s4_down", 2, 32'h0000_0041);
      pin("s4_drop", 4, 32'h0000_0008);
      $display("scenario hard-drop priority done");

      // Rotate held 10 edges
      start_scen();
      repeat (10) cyc(KT);
      repeat (2) cyc('0);
      pin("s5_rot", 3, 32'h0000_0001);
      $display("scenario rotate done");

      // Left held across enable rising; needs re-press
      start_scen();
      en = 1'b0;
      repeat (3) cyc(KL);
      en = 1'b1;
      repeat (5) cyc(KL);
      cyc('0);
      repeat (3) cyc(KL);
      repeat (2) cyc('0);
      pin("s5_enable", 0, 32'h0000_0200);
      $display("scenario enable done");

      // Asynchronous reset while repeating
      start_scen();
      repeat (7) cyc(KL);
      vectors++;
      if (ml !== 1'b1) begin
         miscompares++;
         $display("FAIL s6_pre_reset: move_left=%b required 1", ml);
      end
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({mdrop, mrot, md, mr, ml} !== 5'b00000) begin
         miscompares++;
         $display("FAIL s6_async_reset: outputs=%b required 00000",
                  {mdrop, mrot, md, mr, ml});
      end
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      start_scen();
      repeat (6) cyc(KL);
      repeat (2) cyc('0);
      pin("s6_left", 0, 32'h0000_0011);
      $display("scenario async reset done");

      // Random key activity
      rk = '0;
      for (int i = 0; i < 3000; i++) begin
         for (int b = 0; b < 5; b++) begin
            if ($urandom_range(5) == 0) rk[b] = ~rk[b];
         end
         if ($urandom_range(99) == 0) en = ~en;
         if (!en && $urandom_range(3) == 0) en = 1'b1;
         cyc(rk);
      end
      $display("random phase done");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
